priority_scan_encoder: RTL and testbench

Parametrised, sequential successor to the combinational priority encoder. Accepts a WIDTH-bit request vector over a valid/ready input handshake. Emits the index of every set bit, one per handshake, in priority order (LSB-first or MSB-first), over a valid/ready output handshake. Used wherever all pending requests in a mask must be serviced in order, not just the highest-priority one.

---
 rtl/priority_scan_encoder.sv | 149 ++++++++++++++
 tb/tb_priority_scan_encoder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: drains a request vector one index per
// output handshake, highest priority first (LSB-first or MSB-first).
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       synchronous active-low reset
//   in_valid_i   data_i valid
//   in_ready_o   block can accept a vector (IDLE, not flushing)
//   data_i       WIDTH-bit request vector
//   flush_i      synchronous abort of the current vector
//   out_valid_o  index_o valid (SCAN)
//   out_ready_i  consumer accepts index_o
//   index_o      index of highest-priority remaining set bit
//   last_o       index_o is the final set bit of this vector
//   empty_o      one-cycle pulse after an all-zero vector is accepted
//   busy_o       scan in progress
module priority_scan_encoder #(
    parameter int WIDTH     = 32,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] data_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [IDX_W-1:0] index_o,
    output logic             last_o,
    output logic             empty_o,
    output logic             busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] mask_d;
    logic             empty_q;
    logic             empty_d;

    logic [WIDTH-1:0] scan_vec;
    logic [WIDTH-1:0] scan_oh;
    logic [WIDTH-1:0] sel_oh;
    logic [WIDTH-1:0] rest;
    logic [IDX_W-1:0] sel_idx;
    logic             accept;
    logic             deliver;

    // For MSB-first the mask is bit-reversed so that a single
    // lowest-set-bit isolation serves both priority orders.
    always_comb begin
        scan_vec = mask_q;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                scan_vec[i] = mask_q[WIDTH-1-i];
            end
        end
    end

    // x & -x keeps only the lowest set bit.
    assign scan_oh = scan_vec & (~scan_vec + WIDTH'(1));

    always_comb begin
        sel_oh = scan_oh;
        if (MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                sel_oh[i] = scan_oh[WIDTH-1-i];
            end
        end
    end

    // One-hot to binary in original bit order; yields 0 on an
    // empty mask so index_o rests at 0 outside SCAN.
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sel_oh[i]) begin
                sel_idx = sel_idx | IDX_W'(i);
            end
        end
    end

    assign rest = mask_q & ~sel_oh;

    assign index_o     = sel_idx;
    assign last_o      = (|mask_q) & ~(|rest);
    assign out_valid_o = (state_q == SCAN);
    assign busy_o      = (state_q == SCAN);
    assign empty_o     = empty_q;
    assign in_ready_o  = rst_ni & (state_q == IDLE) & ~flush_i;

    assign accept  = in_valid_i & in_ready_o;
    assign deliver = out_valid_o & out_ready_i;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        empty_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (|data_i) begin
                        mask_d  = data_i;
                        state_d = SCAN;
                    end else begin
                        empty_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (deliver) begin
                    mask_d = rest;
                    if (last_o) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                mask_d  = '0;
            end
        endcase
        if (flush_i) begin
            state_d = IDLE;
            mask_d  = '0;
            empty_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mask_q  <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            empty_q <= empty_d;
        end
    end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Directed bench for priority_scan_encoder: an LSB-first and an
// MSB-first instance run side by side on the same stimulus.
module tb_priority_scan_encoder;

    localparam int W  = 32;
    localparam int IW = 5;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  data;
    logic          flush;
    logic          out_ready;

    logic          l_ir, l_ov, l_last, l_empty, l_busy;
    logic [IW-1:0] l_idx;
    logic          m_ir, m_ov, m_last, m_empty, m_busy;
    logic [IW-1:0] m_idx;

    int checks = 0;
    int errors = 0;

    priority_scan_encoder #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (l_ir),
        .data_i      (data),
        .flush_i     (flush),
        .out_valid_o (l_ov),
        .out_ready_i (out_ready),
        .index_o     (l_idx),
        .last_o      (l_last),
        .empty_o     (l_empty),
        .busy_o      (l_busy)
    );

    priority_scan_encoder #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (m_ir),
        .data_i      (data),
        .flush_i     (flush),
        .out_valid_o (m_ov),
        .out_ready_i (out_ready),
        .index_o     (m_idx),
        .last_o      (m_last),
        .empty_o     (m_empty),
        .busy_o      (m_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept a vector on the next edge; afterwards the first index is live.
    task automatic load(input logic [W-1:0] v);
        in_valid = 1'b1;
        data     = v;
        step();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; data = '1;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            step();
            checks++;
            if ({l_ov, l_empty, l_busy, l_ir, l_idx, l_last} !== 10'b0)
            begin
                errors++;
                $display("FAIL reset_hold: ov=%b em=%b bz=%b ir=%b idx=%0d last=%b want all 0",
                         l_ov, l_empty, l_busy, l_ir, l_idx, l_last);
            end
        end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        checks++;
        if ({l_ir, m_ir, l_ov, m_ov} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_release: ir=%b%b ov=%b%b want ir=11 ov=00",
                     l_ir, m_ir, l_ov, m_ov);
        end
    endtask

    task automatic test_order();
        logic [IW-1:0] le [3];
        logic [IW-1:0] me [3];
        le = '{5'd0, 5'd4, 5'd31};
        me = '{5'd31, 5'd4, 5'd0};
        out_ready = 1'b1;
        load(32'h8000_0011);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({l_ov, l_idx, l_last, l_ir} !== {1'b1, le[k], k == 2, 1'b0}) begin
                errors++;
                $display("FAIL lsb_order[%0d]: ov=%b idx=%0d last=%b ir=%b want 1/%0d/%b/0",
                         k, l_ov, l_idx, l_last, l_ir, le[k], k == 2);
            end
            checks++;
            if ({m_ov, m_idx, m_last} !== {1'b1, me[k], k == 2}) begin
                errors++;
                $display("FAIL msb_order[%0d]: ov=%b idx=%0d last=%b want 1/%0d/%b",
                         k, m_ov, m_idx, m_last, me[k], k == 2);
            end
            step();
        end
        checks++;
        if ({l_ov, l_ir, m_ov, m_ir} !== 4'b0101) begin
            errors++;
            $display("FAIL order_done: ov/ir lsb=%b%b msb=%b%b want 01 01",
                     l_ov, l_ir, m_ov, m_ir);
        end
    endtask

    task automatic test_empty();
        load('0);
        checks++;
        if ({l_empty, l_ov, l_ir, l_busy} !== 4'b1010) begin
            errors++;
            $display("FAIL empty_pulse: em=%b ov=%b ir=%b bz=%b want 1010",
                     l_empty, l_ov, l_ir, l_busy);
        end
        step();
        checks++;
        if ({l_empty, l_ov, l_ir} !== 3'b001) begin
            errors++;
            $display("FAIL empty_clear: em=%b ov=%b ir=%b want 001",
                     l_empty, l_ov, l_ir);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        load(32'h0000_0006);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({l_ov, l_idx, l_last, m_idx, m_last} !==
                {1'b1, 5'd1, 1'b0, 5'd2, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ov=%b idx=%0d/%0d last=%b/%b want 1 1/2 0/0",
                         k, l_ov, l_idx, m_idx, l_last, m_last);
            end
            if (k < 2) step();
        end
        step();
        out_ready = 1'b1;
        #1;
        checks++;
        if ({l_ov, l_idx, l_last} !== {1'b1, 5'd1, 1'b0}) begin
            errors++;
            $display("FAIL bp_first: ov=%b idx=%0d last=%b want 1/1/0",
                     l_ov, l_idx, l_last);
        end
        step();
        checks++;
        if ({l_ov, l_idx, l_last, m_idx, m_last} !==
            {1'b1, 5'd2, 1'b1, 5'd1, 1'b1}) begin
            errors++;
            $display("FAIL bp_last: ov=%b idx=%0d/%0d last=%b/%b want 1 2/1 1/1",
                     l_ov, l_idx, m_idx, l_last, m_last);
        end
        step();
        checks++;
        if ({l_ov, l_ir} !== 2'b01) begin
            errors++;
            $display("FAIL bp_done: ov=%b ir=%b want 01", l_ov, l_ir);
        end
    endtask

    // use_rst=1 aborts with reset instead of flush.
    task automatic test_abort(input bit use_rst);
        out_ready = 1'b1;
        load('1);
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({l_idx, m_idx, l_last} !== {5'(k), 5'(31 - k), 1'b0}) begin
                errors++;
                $display("FAIL abort%0d_idx[%0d]: idx=%0d/%0d last=%b want %0d/%0d 0",
                         use_rst, k, l_idx, m_idx, l_last, k, 31 - k);
            end
            step();
        end
        out_ready = 1'b0;
        if (use_rst) rst_n = 1'b0;
        else         flush = 1'b1;
        #1;
        checks++;
        if (l_ir !== 1'b0) begin
            errors++;
            $display("FAIL abort%0d_ir_low: ir=%b want 0", use_rst, l_ir);
        end
        step();
        rst_n = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++;
        if ({l_ov, l_busy, l_ir, m_ov, m_ir} !== 5'b00101) begin
            errors++;
            $display("FAIL abort%0d_idle: ov=%b bz=%b ir=%b mov=%b mir=%b want 00101",
                     use_rst, l_ov, l_busy, l_ir, m_ov, m_ir);
        end
        load(32'h0000_0100);
        checks++;
        if ({l_ov, l_idx, l_last, m_idx, m_last} !==
            {1'b1, 5'd8, 1'b1, 5'd8, 1'b1}) begin
            errors++;
            $display("FAIL abort%0d_next: ov=%b idx=%0d/%0d last=%b/%b want 1 8/8 1/1",
                     use_rst, l_ov, l_idx, m_idx, l_last, m_last);
        end
        step();
        checks++;
        if (l_ov !== 1'b0) begin
            errors++;
            $display("FAIL abort%0d_next_done: ov=%b want 0", use_rst, l_ov);
        end
    endtask

    task automatic test_flush_drop();
        flush = 1'b1;
        in_valid = 1'b1;
        data = 32'h0000_0005;
        #1;
        checks++;
        if (l_ir !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop_ir: ir=%b want 0", l_ir);
        end
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if ({l_ov, l_busy, l_empty, l_ir} !== 4'b0001) begin
            errors++;
            $display("FAIL flush_drop_idle: ov=%b bz=%b em=%b ir=%b want 0001",
                     l_ov, l_busy, l_empty, l_ir);
        end
    endtask

    task automatic test_all_ones();
        int n;
        n = 0;
        out_ready = 1'b1;
        load('1);
        while (l_ov === 1'b1 && n < W + 4) begin
            checks++;
            if ({l_idx, l_last, m_idx, m_last} !==
                {5'(n), n == W - 1, 5'(W - 1 - n), n == W - 1}) begin
                errors++;
                $display("FAIL all_ones[%0d]: idx=%0d/%0d last=%b/%b want %0d/%0d %b",
                         n, l_idx, m_idx, l_last, m_last, n, W - 1 - n, n == W - 1);
            end
            n++;
            step();
        end
        checks++;
        if (n !== W) begin
            errors++;
            $display("FAIL all_ones_count: got %0d indices want %0d", n, W);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_valid = 1'b1;
        data = 32'h0000_0003;
        step();
        checks++;
        if ({l_ov, l_idx, l_ir} !== {1'b1, 5'd0, 1'b0}) begin
            errors++;
            $display("FAIL b2b_0: ov=%b idx=%0d ir=%b want 1/0/0", l_ov, l_idx, l_ir);
        end
        step();
        checks++;
        if ({l_ov, l_idx, l_last} !== {1'b1, 5'd1, 1'b1}) begin
            errors++;
            $display("FAIL b2b_1: ov=%b idx=%0d last=%b want 1/1/1", l_ov, l_idx, l_last);
        end
        step();
        checks++;
        if ({l_ov, l_ir} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_gap: ov=%b ir=%b want 01", l_ov, l_ir);
        end
        step();
        in_valid = 1'b0;
        #1;
        checks++;
        if ({l_ov, l_idx} !== {1'b1, 5'd0}) begin
            errors++;
            $display("FAIL b2b_next: ov=%b idx=%0d want 1/0", l_ov, l_idx);
        end
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_order();
        test_empty();
        test_backpressure();
        test_abort(1'b0);
        test_abort(1'b1);
        test_flush_drop();
        test_all_ones();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
